// File: rtl/sram_ctrl_256x6.sv
// rtl/sram_ctrl_256x6.sv - 256x6 SRAM controller with power-up init sweep and read/write request ports
// Optional feature macro: SRAM_CTRL_HOLD_READ_EN (hold last read response data until the next response)

module sram_ctrl_256x6 #(
    parameter logic [5:0] INIT_VALUE = 6'h00
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       rreq_valid,
    output logic       rreq_ready,
    input  logic [7:0] rreq_addr,
    output logic       rresp_valid,
    output logic [5:0] rresp_data,
    input  logic       wreq_valid,
    output logic       wreq_ready,
    input  logic [7:0] wreq_addr,
    input  logic [5:0] wreq_data,
    output logic       init_done,
    output logic       arr_ren,
    output logic [7:0] arr_raddr,
    input  logic [5:0] arr_rdata,
    output logic       arr_wen,
    output logic [7:0] arr_waddr,
    output logic [5:0] arr_wdata,
    output logic       arr_wmask
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       rresp_valid_q, rresp_valid_d;
    logic       run;
    logic       rd_acc;
    logic       wr_acc;

    // Request handshakes and array port steering: the sweep owns the write port in INIT
    always_comb begin
        run        = (state_q == ST_RUN);
        rreq_ready = run & ~clear;
        wreq_ready = run & ~clear;
        rd_acc     = rreq_valid & rreq_ready;
        wr_acc     = wreq_valid & wreq_ready;
        init_done  = run;

        arr_ren    = rd_acc;
        arr_raddr  = rreq_addr;

        arr_wmask  = 1'b1;
        if (run) begin
            arr_wen   = wr_acc;
            arr_waddr = wreq_addr;
            arr_wdata = wreq_data;
        end else begin
            arr_wen   = 1'b1;
            arr_waddr = cnt_q;
            arr_wdata = INIT_VALUE;
        end
    end

    // Next-state logic: sweep counter, INIT/RUN transitions, clear restarts the sweep
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rresp_valid_d = rd_acc;

        if (state_q == ST_INIT) begin
            if (clear) begin
                cnt_d = 8'd0;
            end else begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'd255) begin
                    state_d = ST_RUN;
                end
            end
        end else begin
            if (clear) begin
                state_d = ST_INIT;
                cnt_d   = 8'd0;
            end
        end
    end

    // State, sweep counter and response strobe registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_INIT;
            cnt_q         <= 8'd0;
            rresp_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rresp_valid_q <= rresp_valid_d;
        end
    end

    assign rresp_valid = rresp_valid_q;

`ifdef SRAM_CTRL_HOLD_READ_EN
    logic [5:0] hold_q, hold_d;

    // Capture array data in the response cycle so later writes cannot disturb the returned value
    always_comb begin
        hold_d = hold_q;
        if (rresp_valid_q) begin
            hold_d = arr_rdata;
        end
    end

    // Hold register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_q <= 6'd0;
        end else begin
            hold_q <= hold_d;
        end
    end

    assign rresp_data = rresp_valid_q ? arr_rdata : hold_q;
`else
    assign rresp_data = arr_rdata;
`endif

endmodule

// File: tb/tb_sram_ctrl_256x6.sv
// tb/tb_sram_ctrl_256x6.sv - directed self-checking bench for sram_ctrl_256x6 with a behavioural array model

module tb_sram_ctrl_256x6;

    localparam logic [5:0] INIT_V = 6'h2C;

    logic       clock;
    logic       reset;
    logic       clear;
    logic       rreq_valid;
    logic       rreq_ready;
    logic [7:0] rreq_addr;
    logic       rresp_valid;
    logic [5:0] rresp_data;
    logic       wreq_valid;
    logic       wreq_ready;
    logic [7:0] wreq_addr;
    logic [5:0] wreq_data;
    logic       init_done;
    logic       arr_ren;
    logic [7:0] arr_raddr;
    logic [5:0] arr_rdata;
    logic       arr_wen;
    logic [7:0] arr_waddr;
    logic [5:0] arr_wdata;
    logic       arr_wmask;

    int total;
    int bad;
    int n;
    int ren_bad;
    int mem_bad;

    logic [5:0] mem [256];
    logic [7:0] raddr_l;

    sram_ctrl_256x6 #(.INIT_VALUE(INIT_V)) dut (
        .clock       (clock),
        .reset       (reset),
        .clear       (clear),
        .rreq_valid  (rreq_valid),
        .rreq_ready  (rreq_ready),
        .rreq_addr   (rreq_addr),
        .rresp_valid (rresp_valid),
        .rresp_data  (rresp_data),
        .wreq_valid  (wreq_valid),
        .wreq_ready  (wreq_ready),
        .wreq_addr   (wreq_addr),
        .wreq_data   (wreq_data),
        .init_done   (init_done),
        .arr_ren     (arr_ren),
        .arr_raddr   (arr_raddr),
        .arr_rdata   (arr_rdata),
        .arr_wen     (arr_wen),
        .arr_waddr   (arr_waddr),
        .arr_wdata   (arr_wdata),
        .arr_wmask   (arr_wmask)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Array model: address latched on a read, data presented from the current contents
    always @(posedge clock) begin
        if (arr_wen && arr_wmask) mem[arr_waddr] <= arr_wdata;
        if (arr_ren) raddr_l <= arr_raddr;
    end
    assign arr_rdata = mem[raddr_l];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        total = 0; bad = 0;
        raddr_l = 8'd0;
        for (int i = 0; i < 256; i++) mem[i] = ~INIT_V;
        reset = 1'b1; clear = 1'b0;
        rreq_valid = 1'b1; rreq_addr = 8'd0;
        wreq_valid = 1'b0; wreq_addr = 8'd0; wreq_data = 6'd0;

        // Reset state
        repeat (2) @(negedge clock);
        #1;
        chk("rst_init_done", init_done, 0);
        chk("rst_rresp_valid", rresp_valid, 0);
        chk("rst_rreq_ready", rreq_ready, 0);
        chk("rst_wreq_ready", wreq_ready, 0);
        chk("rst_arr_ren", arr_ren, 0);
        chk("rst_arr_wen", arr_wen, 1);
        chk("rst_arr_waddr", arr_waddr, 0);
        chk("rst_arr_wdata", arr_wdata, INIT_V);

        // Init sweep length with a read held pending
        @(negedge clock);
        reset = 1'b0;
        n = 0; ren_bad = 0;
        #1;
        while (rreq_ready !== 1'b1 && n < 1000) begin
            n++;
            if (arr_ren !== 1'b0) ren_bad++;
            @(negedge clock);
            #1;
        end
        chk("sweep_cycles", n, 256);
        chk("sweep_init_done", init_done, 1);
        chk("sweep_no_ren", ren_bad, 0);
        mem_bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== INIT_V) mem_bad++;
        chk("sweep_mem_all_init", mem_bad, 0);

        // Reads of 0, 128, 255 back to back
        chk("rd0_arr_ren", arr_ren, 1);
        chk("rd0_arr_raddr", arr_raddr, 0);
        @(negedge clock);
        rreq_addr = 8'd128;
        #1;
        chk("rd0_valid", rresp_valid, 1);
        chk("rd0_data", rresp_data, INIT_V);
        chk("rd128_arr_raddr", arr_raddr, 128);
        @(negedge clock);
        rreq_addr = 8'd255;
        #1;
        chk("rd128_valid", rresp_valid, 1);
        chk("rd128_data", rresp_data, INIT_V);
        @(negedge clock);
        rreq_valid = 1'b0;
        #1;
        chk("rd255_valid", rresp_valid, 1);
        chk("rd255_data", rresp_data, INIT_V);
        @(negedge clock);
        #1;
        chk("idle_rresp_valid", rresp_valid, 0);
        chk("idle_arr_wen", arr_wen, 0);
        chk("idle_arr_ren", arr_ren, 0);

        // Write 0x2A to 0x10 then read it
        wreq_valid = 1'b1; wreq_addr = 8'h10; wreq_data = 6'h2A;
        #1;
        chk("wr10_ready", wreq_ready, 1);
        chk("wr10_arr_wen", arr_wen, 1);
        chk("wr10_arr_waddr", arr_waddr, 8'h10);
        chk("wr10_arr_wdata", arr_wdata, 6'h2A);
        chk("wr10_arr_wmask", arr_wmask, 1);
        @(negedge clock);
        wreq_valid = 1'b0;
        rreq_valid = 1'b1; rreq_addr = 8'h10;
        #1;
        chk("rd10_no_resp_yet", rresp_valid, 0);
        @(negedge clock);
        rreq_valid = 1'b0;
        #1;
        chk("rd10_valid", rresp_valid, 1);
        chk("rd10_data", rresp_data, 6'h2A);

        // Same-cycle write 0x15 and read of 0x33
        @(negedge clock);
        wreq_valid = 1'b1; wreq_addr = 8'h33; wreq_data = 6'h15;
        rreq_valid = 1'b1; rreq_addr = 8'h33;
        #1;
        chk("rw33_arr_ren", arr_ren, 1);
        chk("rw33_arr_wen", arr_wen, 1);
        @(negedge clock);
        wreq_valid = 1'b0; rreq_valid = 1'b0;
        #1;
        chk("rw33_valid", rresp_valid, 1);
        chk("rw33_data", rresp_data, 6'h15);

        // Hold behaviour: read 0x07 at addr 5, then overwrite with 0x3F
        @(negedge clock);
        wreq_valid = 1'b1; wreq_addr = 8'd5; wreq_data = 6'h07;
        @(negedge clock);
        wreq_valid = 1'b0;
        rreq_valid = 1'b1; rreq_addr = 8'd5;
        @(negedge clock);
        rreq_valid = 1'b0;
        wreq_valid = 1'b1; wreq_addr = 8'd5; wreq_data = 6'h3F;
        #1;
        chk("hold_rd5_data", rresp_data, 6'h07);
        @(negedge clock);
        wreq_valid = 1'b0;
        #1;
        chk("hold_after_valid", rresp_valid, 0);
`ifdef SRAM_CTRL_HOLD_READ_EN
        chk("hold_after_data", rresp_data, 6'h07);
`else
        chk("hold_after_data", rresp_data, 6'h3F);
`endif

        // Clear in RUN with a read accepted the cycle before
        @(negedge clock);
        rreq_valid = 1'b1; rreq_addr = 8'h10;
        @(negedge clock);
        rreq_valid = 1'b0; clear = 1'b1;
        #1;
        chk("clr_resp_valid", rresp_valid, 1);
        chk("clr_resp_data", rresp_data, 6'h2A);
        chk("clr_rreq_ready", rreq_ready, 0);
        chk("clr_wreq_ready", wreq_ready, 0);
        n = 1;
        @(negedge clock);
        clear = 1'b0;
        #1;
        chk("clr_init_done", init_done, 0);
        chk("clr_cnt0", arr_waddr, 0);
        while (rreq_ready !== 1'b1 && n < 1000) begin
            n++;
            @(negedge clock);
            #1;
        end
        chk("clr_ready_low", n, 257);
        rreq_valid = 1'b1; rreq_addr = 8'h10;
        @(negedge clock);
        rreq_valid = 1'b0;
        #1;
        chk("clr_rd10_valid", rresp_valid, 1);
        chk("clr_rd10_data", rresp_data, INIT_V);

        // Reset with a response pending, then reset mid-sweep at cnt=100
        @(negedge clock);
        wreq_valid = 1'b1; wreq_addr = 8'h33; wreq_data = 6'h15;
        @(negedge clock);
        wreq_valid = 1'b0;
        rreq_valid = 1'b1; rreq_addr = 8'h33;
        @(negedge clock);
        rreq_valid = 1'b0;
        #1;
        chk("pend_valid", rresp_valid, 1);
        reset = 1'b1;
        #1;
        chk("pend_rst_valid", rresp_valid, 0);
        chk("pend_rst_init_done", init_done, 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (100) @(negedge clock);
        #1;
        chk("mid_cnt100", arr_waddr, 100);
        chk("mid_wdata", arr_wdata, INIT_V);
        rreq_valid = 1'b1; rreq_addr = 8'h33;
        reset = 1'b1;
        #1;
        chk("mid_rst_waddr", arr_waddr, 0);
        chk("mid_rst_wen", arr_wen, 1);
        chk("mid_rst_ren", arr_ren, 0);
        chk("mid_rst_wready", wreq_ready, 0);
        chk("mid_rst_rready", rreq_ready, 0);
        @(negedge clock);
        reset = 1'b0;
        n = 0;
        #1;
        while (rreq_ready !== 1'b1 && n < 1000) begin
            n++;
            @(negedge clock);
            #1;
        end
        chk("mid_resweep_cycles", n, 256);
        chk("mid_rd33_ren", arr_ren, 1);
        @(negedge clock);
        rreq_valid = 1'b0;
        #1;
        chk("mid_rd33_valid", rresp_valid, 1);
        chk("mid_rd33_data", rresp_data, INIT_V);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
